// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/response bundle for the immediate encoder.
//   Request  : iValid/oReady handshake with iImm_type, iImmediate, iTemplate.
//   Response : oValid/iReady handshake with oInstruction, oError.
//   Counter  : iClr_count in, oErr_count out.
//   slave  modport = encoder side, master modport = driver side.
interface imm_encoder_if #(
    parameter int CNT_W = 8
);
    logic             iValid;
    logic             oReady;
    logic [4:0]       iImm_type;
    logic [31:0]      iImmediate;
    logic [31:0]      iTemplate;
    logic             oValid;
    logic             iReady;
    logic [31:0]      oInstruction;
    logic             oError;
    logic             iClr_count;
    logic [CNT_W-1:0] oErr_count;

    modport slave (
        input  iValid, iImm_type, iImmediate, iTemplate, iReady, iClr_count,
        output oReady, oValid, oInstruction, oError, oErr_count
    );

    modport master (
        output iValid, iImm_type, iImmediate, iTemplate, iReady, iClr_count,
        input  oReady, oValid, oInstruction, oError, oErr_count
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into an RV32I instruction template
// (inverse of the immediate generator), with range/alignment checking.
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : imm_encoder_if slave modport (request in, result out,
//                saturating count of errored results accepted downstream)
// Two-stage pipeline: stage 1 registers the request and its error bit,
// stage 2 holds the packed instruction until downstream takes it.
module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic         iClk,
    input  logic         iRst,
    imm_encoder_if.slave bus
);
    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [4:0]       s1_type_q, s1_type_d;
    logic [31:0]      s1_imm_q, s1_imm_d;
    logic [31:0]      s1_tmpl_q, s1_tmpl_d;
    logic             s1_err_q, s1_err_d;
    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_instr_q, s2_instr_d;
    logic             s2_err_q, s2_err_d;
    // Error counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        s1_en, s2_en;
    logic        in_err;
    logic [31:0] pk_mask, pk_field, pk_instr;

    assign s2_en = !s2_valid_q || bus.iReady;
    assign s1_en = !s1_valid_q || s2_en;

    // Range / alignment check on the incoming request.
    // A field is in range when its upper bits are all-ones or all-zeros.
    always_comb begin
        in_err = 1'b1;
        case (bus.iImm_type)
            5'b00001,
            5'b00010: in_err = !((&bus.iImmediate[31:11]) || !(|bus.iImmediate[31:11]));
            5'b00100: in_err = bus.iImmediate[0] ||
                               !((&bus.iImmediate[31:12]) || !(|bus.iImmediate[31:12]));
            5'b01000: in_err = |bus.iImmediate[11:0];
            5'b10000: in_err = bus.iImmediate[0] ||
                               !((&bus.iImmediate[31:20]) || !(|bus.iImmediate[31:20]));
            default:  in_err = 1'b1;
        endcase
    end

    // Immediate field placement. An invalid type has an empty mask, so the
    // template passes through untouched.
    always_comb begin
        pk_mask  = 32'h0;
        pk_field = 32'h0;
        case (s1_type_q)
            5'b00001: begin
                pk_mask  = 32'hFFF0_0000;
                pk_field = {s1_imm_q[11:0], 20'b0};
            end
            5'b00010: begin
                pk_mask  = 32'hFE00_0F80;
                pk_field = {s1_imm_q[11:5], 13'b0, s1_imm_q[4:0], 7'b0};
            end
            5'b00100: begin
                pk_mask  = 32'hFE00_0F80;
                pk_field = {s1_imm_q[12], s1_imm_q[10:5], 13'b0,
                            s1_imm_q[4:1], s1_imm_q[11], 7'b0};
            end
            5'b01000: begin
                pk_mask  = 32'hFFFF_F000;
                pk_field = {s1_imm_q[31:12], 12'b0};
            end
            5'b10000: begin
                pk_mask  = 32'hFFFF_F000;
                pk_field = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                            s1_imm_q[19:12], 12'b0};
            end
            default: begin
                pk_mask  = 32'h0;
                pk_field = 32'h0;
            end
        endcase
        // On error the immediate fields are zeroed rather than filled.
        pk_instr = (s1_tmpl_q & ~pk_mask) | (s1_err_q ? 32'h0 : (pk_field & pk_mask));
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_type_d  = s1_type_q;
        s1_imm_d   = s1_imm_q;
        s1_tmpl_d  = s1_tmpl_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        cnt_d      = cnt_q;

        if (s1_en) begin
            s1_valid_d = bus.iValid;
            if (bus.iValid) begin
                s1_type_d = bus.iImm_type;
                s1_imm_d  = bus.iImmediate;
                s1_tmpl_d = bus.iTemplate;
                s1_err_d  = in_err;
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pk_instr;
                s2_err_d   = s1_err_q;
            end
        end

        // Clear takes priority over a coincident increment.
        if (bus.iClr_count)
            cnt_d = '0;
        else if (s2_valid_q && bus.iReady && s2_err_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_valid_q <= 1'b0;
            s1_type_q  <= '0;
            s1_imm_q   <= '0;
            s1_tmpl_q  <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_type_q  <= s1_type_d;
            s1_imm_q   <= s1_imm_d;
            s1_tmpl_q  <= s1_tmpl_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.oReady       = s1_en;
    assign bus.oValid       = s2_valid_q;
    assign bus.oInstruction = s2_instr_q;
    assign bus.oError       = s2_err_q;
    assign bus.oErr_count   = cnt_q;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed-vector bench for imm_encoder.
module tb_imm_encoder;
    localparam int CNT_W = 8;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    imm_encoder_if #(.CNT_W(CNT_W)) bus ();

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
    );

    always #5 iClk = ~iClk;

    localparam logic [4:0] T_I = 5'b00001, T_S = 5'b00010, T_B = 5'b00100,
                           T_U = 5'b01000, T_J = 5'b10000;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_in();
        bus.iValid     = 1'b0;
        bus.iImm_type  = 5'b0;
        bus.iImmediate = 32'h0;
        bus.iTemplate  = 32'h0;
        bus.iClr_count = 1'b0;
    endtask

    task automatic drive(input logic [4:0] t, input logic [31:0] imm, input logic [31:0] tmpl);
        bus.iValid     = 1'b1;
        bus.iImm_type  = t;
        bus.iImmediate = imm;
        bus.iTemplate  = tmpl;
    endtask

    task automatic test_reset();
        idle_in();
        bus.iReady = 1'b1;
        #12;
        n_total++;
        if (bus.oValid !== 1'b0 || bus.oInstruction !== 32'h0 || bus.oError !== 1'b0 || bus.oErr_count !== 8'd0)
            $display("FAIL reset_outputs: oValid=%b instr=%h err=%b cnt=%0d, want 0/0/0/0",
                     bus.oValid, bus.oInstruction, bus.oError, bus.oErr_count);
        else n_pass++;
        @(negedge iClk);
        iRst = 1'b0;
        step();
        n_total++;
        if (bus.oReady !== 1'b1) $display("FAIL reset_ready: oReady=%b want 1", bus.oReady);
        else n_pass++;
    endtask

    // Single request with iReady=1: checks latency and packed result.
    task automatic send_one(input string nm, input logic [4:0] t, input logic [31:0] imm,
                            input logic [31:0] tmpl, input logic [31:0] exp_i, input logic exp_e);
        bus.iReady = 1'b1;
        drive(t, imm, tmpl);
        #1;
        n_total++;
        if (bus.oReady !== 1'b1) $display("FAIL %s_ready: oReady=%b want 1", nm, bus.oReady);
        else n_pass++;
        step();
        idle_in();
        n_total++;
        if (bus.oValid !== 1'b0) $display("FAIL %s_early: oValid=%b want 0 one cycle after accept", nm, bus.oValid);
        else n_pass++;
        step();
        n_total++;
        if (bus.oValid !== 1'b1 || bus.oInstruction !== exp_i || bus.oError !== exp_e)
            $display("FAIL %s: oValid=%b instr=%h err=%b, want 1/%h/%b",
                     nm, bus.oValid, bus.oInstruction, bus.oError, exp_i, exp_e);
        else n_pass++;
        step();
    endtask

    task automatic test_types();
        send_one("i_neg1",  T_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        send_one("b_neg2",  T_B, 32'hFFFF_FFFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0);
        send_one("s_min",   T_S, 32'hFFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0);
        send_one("i_range", T_I, 32'h0000_0800, 32'h1234_5678, 32'h0004_5678, 1'b1);
        send_one("u_align", T_U, 32'h1234_5001, 32'hFFFF_FFFF, 32'h0000_0FFF, 1'b1);
        send_one("b_odd",   T_B, 32'h0000_0002 | 32'h1, 32'hFFFF_FFFF, 32'h01FF_F07F, 1'b1);
    endtask

    // U then J back-to-back; J is misaligned and must bump the counter.
    task automatic test_back_to_back();
        bus.iClr_count = 1'b1;
        step();
        bus.iClr_count = 1'b0;
        bus.iReady = 1'b1;
        drive(T_U, 32'h1234_5000, 32'h0000_0037);
        step();
        drive(T_J, 32'h0000_0801, 32'h0000_006F);
        step();
        idle_in();
        n_total++;
        if (bus.oValid !== 1'b1 || bus.oInstruction !== 32'h1234_5037 || bus.oError !== 1'b0)
            $display("FAIL b2b_u: oValid=%b instr=%h err=%b, want 1/12345037/0",
                     bus.oValid, bus.oInstruction, bus.oError);
        else n_pass++;
        step();
        n_total++;
        if (bus.oValid !== 1'b1 || bus.oInstruction !== 32'h0000_006F || bus.oError !== 1'b1)
            $display("FAIL b2b_j: oValid=%b instr=%h err=%b, want 1/0000006f/1",
                     bus.oValid, bus.oInstruction, bus.oError);
        else n_pass++;
        step();
        n_total++;
        if (bus.oErr_count !== 8'd1) $display("FAIL b2b_cnt: oErr_count=%0d want 1", bus.oErr_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic [31:0] exp_v [3];
        int sent;
        exp_v[0] = 32'h0010_0013;
        exp_v[1] = 32'h0020_0013;
        exp_v[2] = 32'h0030_0013;
        bus.iReady = 1'b0;
        drive(T_I, 32'd1, 32'h13);
        step();
        drive(T_I, 32'd2, 32'h13);
        step();
        drive(T_I, 32'd3, 32'h13);
        #1;
        n_total++;
        if (bus.oReady !== 1'b0) $display("FAIL bp_full: oReady=%b want 0 with 2 buffered", bus.oReady);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_total++;
            if (bus.oValid !== 1'b1 || bus.oInstruction !== exp_v[0] || bus.oReady !== 1'b0)
                $display("FAIL bp_hold%0d: oValid=%b instr=%h oReady=%b, want 1/%h/0",
                         c, bus.oValid, bus.oInstruction, bus.oReady, exp_v[0]);
            else n_pass++;
            step();
        end
        bus.iReady = 1'b1;
        sent = 2;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            #1;
            if (bus.oValid === 1'b1) got.push_back(bus.oInstruction);
            if (bus.iValid && bus.oReady) sent++;
            step();
            if (sent == 3) idle_in();
        end
        n_total++;
        if (got.size() != 3) $display("FAIL bp_count: got %0d results want 3", got.size());
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (k >= got.size()) $display("FAIL bp_order%0d: missing, want %h", k, exp_v[k]);
            else if (got[k] !== exp_v[k]) $display("FAIL bp_order%0d: got %h want %h", k, got[k], exp_v[k]);
            else n_pass++;
        end
        step();
        n_total++;
        if (bus.oValid !== 1'b0) $display("FAIL bp_dup: oValid=%b want 0 after drain", bus.oValid);
        else n_pass++;
    endtask

    task automatic test_saturate();
        bus.iClr_count = 1'b1;
        bus.iReady = 1'b1;
        step();
        bus.iClr_count = 1'b0;
        drive(5'b00011, 32'h0, 32'hABCD_E0B3);
        step();
        step();
        n_total++;
        if (bus.oValid !== 1'b1 || bus.oInstruction !== 32'hABCD_E0B3 || bus.oError !== 1'b1)
            $display("FAIL inv_type: oValid=%b instr=%h err=%b, want 1/abcde0b3/1",
                     bus.oValid, bus.oInstruction, bus.oError);
        else n_pass++;
        for (int k = 2; k < 300; k++) step();
        idle_in();
        for (int k = 0; k < 4; k++) step();
        n_total++;
        if (bus.oErr_count !== 8'd255) $display("FAIL cnt_sat: oErr_count=%0d want 255", bus.oErr_count);
        else n_pass++;
        // Clear coinciding with an accepted error.
        drive(5'b00000, 32'h0, 32'h1);
        step();
        idle_in();
        step();
        bus.iClr_count = 1'b1;
        #1;
        n_total++;
        if (bus.oValid !== 1'b1 || bus.oError !== 1'b1) $display("FAIL clr_setup: oValid=%b err=%b want 1/1", bus.oValid, bus.oError);
        else n_pass++;
        step();
        bus.iClr_count = 1'b0;
        n_total++;
        if (bus.oErr_count !== 8'd0) $display("FAIL cnt_clr: oErr_count=%0d want 0", bus.oErr_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.iReady = 1'b1;
        drive(T_J, 32'h1, 32'h6F);
        step();
        idle_in();
        step();
        step();
        n_total++;
        if (bus.oErr_count !== 8'd1) $display("FAIL rst_pre_cnt: oErr_count=%0d want 1", bus.oErr_count);
        else n_pass++;
        bus.iReady = 1'b0;
        drive(T_I, 32'd5, 32'h13);
        step();
        drive(T_I, 32'd6, 32'h13);
        step();
        idle_in();
        #2;
        iRst = 1'b1;
        #1;
        n_total++;
        if (bus.oValid !== 1'b0 || bus.oErr_count !== 8'd0 || bus.oInstruction !== 32'h0)
            $display("FAIL rst_async: oValid=%b cnt=%0d instr=%h, want 0/0/0",
                     bus.oValid, bus.oErr_count, bus.oInstruction);
        else n_pass++;
        bus.iReady = 1'b1;
        #3;
        iRst = 1'b0;
        step();
        n_total++;
        if (bus.oReady !== 1'b1) $display("FAIL rst_ready: oReady=%b want 1", bus.oReady);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_total++;
            if (bus.oValid !== 1'b0) $display("FAIL rst_stale%0d: oValid=%b want 0", c, bus.oValid);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_types();
        test_back_to_back();
        test_backpressure();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
